// File: rtl/mau_pkg.sv
// Shared size codes and FSM state encodings for the data-memory access unit.
package mau_pkg;

  localparam logic [1:0] MAU_SIZE_B = 2'd0;
  localparam logic [1:0] MAU_SIZE_H = 2'd1;
  localparam logic [1:0] MAU_SIZE_W = 2'd2;
  localparam logic [1:0] MAU_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    MAU_ST_IDLE = 2'd0,
    MAU_ST_RD   = 2'd1,
    MAU_ST_WR   = 2'd2,
    MAU_ST_RESP = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane alignment: load extract/extend, store lane mask and merge.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [OFS_W-1:0]  ofs,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld,
  output logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] sh,
  output logic [DATA_W-1:0] merged
);

  logic [OFS_W+2:0]  sa;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] wm;
  logic              sgn;

  assign sa = {ofs, 3'b000};

  always_comb begin
    wm   = '0;
    sgn  = 1'b0;
    lane = word >> sa;
    unique case (size)
      MAU_SIZE_B: begin
        wm  = DATA_W'(8'hFF);
        sgn = lane[7];
      end
      MAU_SIZE_H: begin
        wm  = DATA_W'(16'hFFFF);
        sgn = lane[15];
      end
      MAU_SIZE_W: begin
        wm  = DATA_W'(32'hFFFF_FFFF);
        sgn = lane[31];
      end
      default: begin
        wm  = '1;
        sgn = lane[DATA_W-1];
      end
    endcase
    ld     = (lane & wm)
           | (~wm & {DATA_W{sgn & ~uns}});
    mask   = wm << sa;
    sh     = wdata << sa;
    merged = (word & ~mask) | (sh & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU MEM-stage to data-memory access unit with req/ack handshake.
// MAU_BYTE_EN_EN: byte-strobe stores (mem_be port) instead of RMW.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MAU_BYTE_EN_EN
  ,
  output logic [DATA_W/8-1:0] mem_be
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);
  localparam logic [1:0] FULL =
    (DATA_W == 64) ? MAU_SIZE_D : MAU_SIZE_W;
`ifdef MAU_BYTE_EN_EN
  localparam logic BE_EN = 1'b1;
`else
  localparam logic BE_EN = 1'b0;
`endif

  mau_state_e state, state_n;

  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_we;
  logic              a_uns;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [OFS_W-1:0]  ofs;
  logic              bad;
  logic              accept;
  logic [DATA_W-1:0] word_in;
  logic [DATA_W-1:0] ld;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] merged;

  assign ofs    = req_addr[OFS_W-1:0];
  assign accept = req_valid & (state == MAU_ST_IDLE);

  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      MAU_SIZE_B: bad = 1'b0;
      MAU_SIZE_H: bad = ofs[0];
      MAU_SIZE_W: bad = (ofs[1:0] != 2'b00);
      default:    bad = (DATA_W != 64) || (ofs != '0);
    endcase
  end

  // Loads extract straight from the bus; merges use the captured word.
  assign word_in = (state == MAU_ST_RD) ? mem_rdata : old_q;

  mau_lane_align #(
    .DATA_W (DATA_W),
    .OFS_W  (OFS_W)
  ) u_align (
    .ofs    (a_addr[OFS_W-1:0]),
    .size   (a_size),
    .uns    (a_uns),
    .word   (word_in),
    .wdata  (a_wdata),
    .ld     (ld),
    .mask   (mask),
    .sh     (sh),
    .merged (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= MAU_ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MAU_ST_IDLE: begin
        if (req_valid) begin
          if (bad)
            state_n = MAU_ST_RESP;
          else if (req_we && (BE_EN || req_size == FULL))
            state_n = MAU_ST_WR;
          else
            state_n = MAU_ST_RD;
        end
      end
      MAU_ST_RD: begin
        if (mem_ack)
          state_n = a_we ? MAU_ST_WR : MAU_ST_RESP;
      end
      MAU_ST_WR: begin
        if (mem_ack) state_n = MAU_ST_RESP;
      end
      default: state_n = MAU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_addr  <= '0;
      a_size  <= '0;
      a_we    <= 1'b0;
      a_uns   <= 1'b0;
      a_wdata <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_addr  <= req_addr;
        a_size  <= req_size;
        a_we    <= req_we;
        a_uns   <= req_unsigned;
        a_wdata <= req_wdata;
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (state == MAU_ST_RD && mem_ack) begin
        old_q <= mem_rdata;
        if (!a_we) rdata_q <= ld;
      end
    end
  end

  assign req_ready  = (state == MAU_ST_IDLE);
  assign resp_valid = (state == MAU_ST_RESP);
  assign resp_err   = (state == MAU_ST_RESP) & err_q;
  assign resp_rdata =
    (state == MAU_ST_RESP) ? rdata_q : '0;
  assign mem_req    = (state == MAU_ST_RD)
                    | (state == MAU_ST_WR);
  assign mem_we     = (state == MAU_ST_WR);
  assign mem_addr   =
    {a_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

`ifdef MAU_BYTE_EN_EN
  assign mem_wdata = (state == MAU_ST_WR) ? sh : '0;

  always_comb begin
    mem_be = '0;
    for (int i = 0; i < NB; i++) begin
      if (state == MAU_ST_WR)     mem_be[i] = mask[8*i];
      else if (state == MAU_ST_RD) mem_be[i] = 1'b1;
    end
  end

  logic unused_lane;
  assign unused_lane = ^merged;
`else
  assign mem_wdata = (state == MAU_ST_WR) ? merged : '0;

  logic unused_lane;
  assign unused_lane = ^{mask, sh};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (32-bit, RMW store build).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef MAU_BYTE_EN_EN
  logic [3:0]  mem_be;
`endif

  mem_access_unit #(
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
`ifdef MAU_BYTE_EN_EN
    ,
    .mem_be       (mem_be)
`endif
  );

  always #5 clk = ~clk;

  // Memory model with programmable ack delay
  logic [31:0] mem [0:31];
  int          wait_cnt = 0;
  int          ack_delay = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] last_addr = '0;
  logic        force_ack = 1'b0;
  logic        pre_en = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  assign mem_ack   = force_ack
                   | (mem_req && (wait_cnt >= ack_delay));
  assign mem_rdata = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (mem_req && mem_ack) begin
      last_addr <= mem_addr;
      if (mem_we) begin
        mem[mem_addr[6:2]] <= mem_wdata;
        n_wr <= n_wr + 1;
      end else begin
        n_rd <= n_rd + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx,
                         input logic [31:0] val);
    @(negedge clk);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic drive(input logic we,
                       input logic [1:0] sz,
                       input logic uns,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'hFFFF_FFFF;
  endtask

  // lat = cycles from the accept edge to resp_valid; -1 on timeout
  task automatic do_req(input logic we,
                        input logic [1:0] sz,
                        input logic uns,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        output int lat,
                        output logic err,
                        output logic [31:0] rd,
                        output int drd,
                        output int dwr,
                        output logic again);
    int rd0, wr0;
    rd0   = n_rd;
    wr0   = n_wr;
    lat   = -1;
    err   = 1'bx;
    rd    = 'x;
    again = 1'bx;
    drive(we, sz, uns, a, wd);
    for (int i = 1; i <= 50; i++) begin
      if (resp_valid) begin
        lat = i;
        err = resp_err;
        rd  = resp_rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    again = resp_valid;
    drd   = n_rd - rd0;
    dwr   = n_wr - wr0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] old;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] newword;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  localparam int NV = 16;
  vec_t tv [NV];

  int          lat, drd, dwr;
  logic        err, again;
  logic [31:0] rd;
  int          nreq, nresp, rdy_bad, seen;
  logic [31:0] got;

  initial begin
    tv[0]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,
               32'h80FF_7F01, 1'b0, 32'hFFFF_FF80,
               32'h80FF_7F01, 2, 1, 0};
    tv[1]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,
               32'h80FF_7F01, 1'b0, 32'h0000_0080,
               32'h80FF_7F01, 2, 1, 0};
    tv[2]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,
               32'h80FF_7F01, 1'b0, 32'hFFFF_FFFF,
               32'h80FF_7F01, 2, 1, 0};
    tv[3]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,
               32'h80FF_7F01, 1'b0, 32'h0000_007F,
               32'h80FF_7F01, 2, 1, 0};
    tv[4]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,
               32'h8001_1234, 1'b0, 32'h0000_8001,
               32'h8001_1234, 2, 1, 0};
    tv[5]  = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,
               32'h8001_1234, 1'b0, 32'hFFFF_8001,
               32'h8001_1234, 2, 1, 0};
    tv[6]  = '{1'b0, 2'd1, 1'b0, 32'h20, 32'h0,
               32'h8001_1234, 1'b0, 32'h0000_1234,
               32'h8001_1234, 2, 1, 0};
    tv[7]  = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0,
               32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, 2, 1, 0};
    tv[8]  = '{1'b1, 2'd0, 1'b0, 32'h41, 32'hAB,
               32'h1122_3344, 1'b0, 32'h0,
               32'h1122_AB44, 3, 1, 1};
    tv[9]  = '{1'b1, 2'd1, 1'b0, 32'h52, 32'hFFFF_CAFE,
               32'h1122_3344, 1'b0, 32'h0,
               32'hCAFE_3344, 3, 1, 1};
    tv[10] = '{1'b1, 2'd2, 1'b0, 32'h60, 32'h1234_5678,
               32'hAAAA_AAAA, 1'b0, 32'h0,
               32'h1234_5678, 2, 0, 1};
    tv[11] = '{1'b1, 2'd0, 1'b0, 32'h73, 32'h1234_5699,
               32'h0, 1'b0, 32'h0,
               32'h9900_0000, 3, 1, 1};
    tv[12] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,
               32'h5555_5555, 1'b1, 32'h0,
               32'h5555_5555, 1, 0, 0};
    tv[13] = '{1'b0, 2'd1, 1'b0, 32'h23, 32'h0,
               32'h5555_5555, 1'b1, 32'h0,
               32'h5555_5555, 1, 0, 0};
    tv[14] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,
               32'h5555_5555, 1'b1, 32'h0,
               32'h5555_5555, 1, 0, 0};
    tv[15] = '{1'b1, 2'd2, 1'b0, 32'h42, 32'hFFFF_FFFF,
               32'h7777_7777, 1'b1, 32'h0,
               32'h7777_7777, 1, 0, 0};

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_mreq", 32'(mem_req), 32'd0);
    chk("rst_mwe", 32'(mem_we), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Stray acks while idle must be ignored
    force_ack = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid || !req_ready) seen++;
    end
    @(negedge clk);
    force_ack = 1'b0;
    chk("idle_ack", 32'(seen), 32'd0);

    for (int i = 0; i < NV; i++) begin
      preload(tv[i].addr[6:2], tv[i].old);
      do_req(tv[i].we, tv[i].sz, tv[i].uns,
             tv[i].addr, tv[i].wd,
             lat, err, rd, drd, dwr, again);
      chk($sformatf("v%0d_lat", i),
          32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_err", i),
          32'(err), 32'(tv[i].err));
      chk($sformatf("v%0d_rdata", i),
          rd, tv[i].rdata);
      chk($sformatf("v%0d_nrd", i),
          32'(drd), 32'(tv[i].nrd));
      chk($sformatf("v%0d_nwr", i),
          32'(dwr), 32'(tv[i].nwr));
      chk($sformatf("v%0d_pulse", i),
          32'(again), 32'd0);
      chk($sformatf("v%0d_mem", i),
          mem[tv[i].addr[6:2]], tv[i].newword);
      if (tv[i].nrd + tv[i].nwr > 0)
        chk($sformatf("v%0d_maddr", i),
            last_addr, tv[i].addr & 32'hFFFF_FFFC);
    end

    // Slow memory: ack 5 cycles late in RD
    preload(5'd12, 32'hDEAD_BEEF);
    ack_delay = 5;
    drive(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    nreq    = 0;
    nresp   = 0;
    rdy_bad = 0;
    got     = '0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req) nreq++;
      if (resp_valid) begin
        nresp++;
        got = resp_rdata;
      end else if (nresp == 0 && req_ready) begin
        rdy_bad++;
      end
      @(posedge clk);
      #1;
    end
    ack_delay = 0;
    chk("slow_mreq", 32'(nreq), 32'd6);
    chk("slow_nresp", 32'(nresp), 32'd1);
    chk("slow_ready", 32'(rdy_bad), 32'd0);
    chk("slow_rdata", got, 32'hDEAD_BEEF);

    // Reset while a write is outstanding
    preload(5'd24, 32'hAAAA_AAAA);
    ack_delay = 3;
    drive(1'b1, 2'd2, 1'b0, 32'h60, 32'h1234_5678);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_req && mem_we) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("rstwr_inwr", 32'(seen), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstwr_mreq", 32'(mem_req), 32'd0);
    chk("rstwr_ready", 32'(req_ready), 32'd1);
    chk("rstwr_resp", 32'(resp_valid), 32'd0);
    chk("rstwr_maddr", mem_addr, 32'h0);
    chk("rstwr_mwdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    chk("rstwr_noresp", 32'(seen), 32'd0);
    chk("rstwr_mem", mem[24], 32'hAAAA_AAAA);
    ack_delay = 0;
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0,
           lat, err, rd, drd, dwr, again);
    chk("post_lat", 32'(lat), 32'd2);
    chk("post_err", 32'(err), 32'd0);
    chk("post_rdata", rd, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
